// File: rtl/frq_pkg.sv
// Shared types and constants for the frequency sweep controller.
// Holds the FSM state encoding, the divisor width and the default step count.
// Also provides the modulo-8 divisor stepping helper used by the controller.
package frq_pkg;

    localparam int DIV_W     = 3;
    localparam int STEPS_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Next divisor setting; the 3-bit width gives the 7->0 / 0->7 wrap for free.
    function automatic logic [DIV_W-1:0] step_div(input logic [DIV_W-1:0] v,
                                                  input logic             up);
        return up ? v + DIV_W'(1) : v - DIV_W'(1);
    endfunction

endpackage

// File: rtl/frq_burst_cnt.sv
// Burst pulse counter: counts enabled pulses and flags the one that reaches the limit.
// Latency: hit_o is combinational on the pulse that completes the burst.
// No backpressure; a limit of 0 behaves as 1.
module frq_burst_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         hit_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] lim;

    assign lim   = (limit_i == '0) ? W'(1) : limit_i;
    // cnt_q never exceeds lim-1, so the increment cannot overflow W bits.
    assign hit_o = en_i && ((cnt_q + W'(1)) == lim);

    // Next count: clear has priority, and the counter rewinds on the completing pulse.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = hit_o ? '0 : cnt_q + W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/frq_sweep_ctrl.sv
// Divisor sweep controller: loads STEPS successive divisor settings, holding each for a burst of div_co pulses.
// Latency: start -> div_ld next cycle, COUNT the cycle after; done one cycle after the final counted pulse.
// No backpressure; start outside IDLE is dropped, abort returns to IDLE without done.
module frq_sweep_ctrl
    import frq_pkg::*;
#(
    parameter int STEPS   = STEPS_DEF,
    parameter int BURST_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [DIV_W-1:0]   SW,
    input  logic               dir,
    input  logic [BURST_W-1:0] burst,
    input  logic               div_co,
    output logic               div_ld,
    output logic [DIV_W-1:0]   div_val,
    output logic               out,
    output logic               busy,
    output logic               done,
    output logic [DIV_W-1:0]   step_idx
);

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   cur_q, cur_d;
    logic [DIV_W-1:0]   step_q, step_d;
    logic               dir_q, dir_d;
    logic [BURST_W-1:0] burst_q, burst_d;

    logic cnt_en;
    logic cnt_clr;
    logic cnt_hit;
    logic last_step;

    // Pulses only count while in COUNT; the count is held clear everywhere else,
    // which covers the clear-on-entry-to-LOAD behaviour.
    assign cnt_en    = (state_q == ST_COUNT) && div_co;
    assign cnt_clr   = (state_q != ST_COUNT);
    assign last_step = (step_q == DIV_W'(STEPS - 1));

    frq_burst_cnt #(
        .W (BURST_W)
    ) u_burst_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .limit_i (burst_q),
        .hit_o   (cnt_hit)
    );

    // Next-state logic: latch the sweep setup in IDLE, advance a step per completed burst.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        step_d  = step_q;
        dir_d   = dir_q;
        burst_d = burst_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    cur_d   = SW;
                    dir_d   = dir;
                    burst_d = burst;
                    step_d  = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = abort ? ST_IDLE : ST_COUNT;
            end
            ST_COUNT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_hit) begin
                    if (last_step) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_d   = step_div(cur_q, dir_q);
                        step_d  = step_q + DIV_W'(1);
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and sweep registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            step_q  <= '0;
            dir_q   <= 1'b0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            burst_q <= burst_d;
        end
    end

    assign div_ld   = (state_q == ST_LOAD);
    assign div_val  = cur_q;
    assign out      = div_co && (state_q == ST_COUNT);
    assign busy     = (state_q == ST_LOAD) || (state_q == ST_COUNT);
    assign done     = (state_q == ST_DONE);
    assign step_idx = step_q;

endmodule

// File: doc/frq_sweep_ctrl.md
FRQ_SWEEP_CTRL -- requirements
Module: frq_sweep_ctrl

Interface
REQ-001 Parameter STEPS, default 8: number of divisor settings per sweep, legal range 1..8.
REQ-002 Parameter BURST_W, default 4: width of the burst-length input.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle sweep request.
REQ-006 abort  input  1  terminate the sweep in progress.
REQ-007 SW  input  3  first divisor setting of the sweep.
REQ-008 dir  input  1  step direction: 1 = increment, 0 = decrement.
REQ-009 burst  input  BURST_W  number of divider output pulses to hold each setting.
REQ-010 div_co  input  1  carry-out pulse from the controlled divider.
REQ-011 div_ld  output  1  one-cycle load strobe to the divider.
REQ-012 div_val  output  3  divisor value presented with div_ld.
REQ-013 out  output  1  div_co gated to the COUNT state.
REQ-014 busy  output  1  high in LOAD and COUNT.
REQ-015 done  output  1  one-cycle sweep-complete pulse.
REQ-016 step_idx  output  3  index of the current step, 0-based.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, COUNT and DONE.
REQ-018 IDLE: on start=1, SW, dir and burst SHALL be latched, with step_idx=0 and cur=SW; the next state SHALL be LOAD.
REQ-019 LOAD SHALL last exactly one cycle, with div_ld=1 and div_val=cur; the next state SHALL be COUNT.
REQ-020 Start sampled in cycle t SHALL produce div_ld=1 in cycle t+1 and COUNT in cycle t+2.
REQ-021 COUNT SHALL count div_co pulses. When the count reaches the latched burst in cycle c:
  - if step_idx = STEPS-1, the state in cycle c+1 SHALL be DONE;
  - otherwise, the state in cycle c+1 SHALL be LOAD, with cur stepped and step_idx incremented.
REQ-022 The burst count SHALL clear on every entry to LOAD.
REQ-023 A latched burst value of 0 SHALL be treated as 1.
REQ-024 cur SHALL step modulo 8 in both directions: 7+1 = 0 and 0-1 = 7.
REQ-025 div_val SHALL hold cur in all states (it is valid only while div_ld=1).
REQ-026 div_co SHALL be ignored outside COUNT, including in the LOAD cycle.
REQ-027 out SHALL equal div_co AND (state == COUNT); it is combinational.
REQ-028 DONE SHALL last one cycle with done=1, then the state SHALL return to IDLE.
REQ-029 Start outside IDLE SHALL be ignored, and no relatch SHALL occur.
REQ-030 abort=1 in LOAD, COUNT or DONE SHALL force IDLE next cycle with no done pulse.
REQ-031 When abort and start are asserted together in IDLE, abort SHALL win and the state SHALL remain IDLE.
REQ-032 Inputs SW, dir and burst SHALL be don't-care after latching; changes mid-sweep SHALL have no effect.

Reset
REQ-033 rst=1 at a clock edge SHALL force IDLE, clear cur, step_idx and the burst count, and set div_ld, done and busy to 0.
REQ-034 rst SHALL take priority over start, abort and div_co in the same cycle.
REQ-035 Reset asserted mid-sweep SHALL produce no done pulse and no div_ld pulse in the following cycle.

Structure
REQ-036 The state encoding, the 3-bit divisor width constant and the STEPS default SHALL live in the shared package frq_pkg.
REQ-037 The burst pulse counter (clear, enable, compare-to-limit) SHALL be a sub-module named frq_burst_cnt.
REQ-038 The FSM, the cur/step registers and the output logic SHALL remain in frq_sweep_ctrl.

Verification
REQ-039 Reset: assert rst for 2 cycles -> busy=0, done=0, div_ld=0, step_idx=0, out=0 regardless of div_co.
REQ-040 Up sweep: STEPS=3, SW=3, dir=1, burst=2, with div_co pulsed every 4 cycles:
  - div_ld pulses with div_val 3, 4, 5;
  - two counted pulses per step;
  - done=1 exactly one cycle after the 6th counted pulse.
REQ-041 Wrap-around: STEPS=3, SW=6, dir=1, burst=1 -> div_val sequence 6, 7, 0; then SW=1, dir=0 -> sequence 1, 0, 7.
REQ-042 Burst zero: burst=0, STEPS=2 -> each step advances after exactly one div_co; a div_co coinciding with the LOAD cycle is not counted and out=0 during that cycle.
REQ-043 Abort: abort asserted in COUNT of step 1 -> IDLE next cycle, busy=0, no done; a following start re-runs the sweep from the new SW.
REQ-044 Busy/reset interaction: start pulsed during COUNT -> ignored, step sequence unchanged; rst asserted mid-COUNT -> IDLE next cycle, no done, no div_ld.
